// File: rtl/vx_raster_csr_pkg.sv
// Shared types for the raster CSR responder: CSR index map, raster configuration
// bundle, responder state encoding and field access helpers.
package vx_raster_csr_pkg;

  localparam int unsigned RASTER_CSR_DATA_BITS  = 32;
  localparam int unsigned RASTER_TILE_DATA_BITS = 16;
  localparam int unsigned RASTER_CSR_ADDR_BITS  = 12;
  localparam int unsigned RASTER_CSR_COUNT      = 9;

  localparam logic [3:0] RASTER_CSR_PIDX_ADDR   = 4'd0;
  localparam logic [3:0] RASTER_CSR_PIDX_SIZE   = 4'd1;
  localparam logic [3:0] RASTER_CSR_PBUF_ADDR   = 4'd2;
  localparam logic [3:0] RASTER_CSR_PBUF_STRIDE = 4'd3;
  localparam logic [3:0] RASTER_CSR_TILE_LEFT   = 4'd4;
  localparam logic [3:0] RASTER_CSR_TILE_TOP    = 4'd5;
  localparam logic [3:0] RASTER_CSR_TILE_WIDTH  = 4'd6;
  localparam logic [3:0] RASTER_CSR_TILE_HEIGHT = 4'd7;
  localparam logic [3:0] RASTER_CSR_CTRL        = 4'd8;

  typedef logic [RASTER_CSR_DATA_BITS-1:0]  csr_data_t;
  typedef logic [RASTER_TILE_DATA_BITS-1:0] tile_data_t;
  typedef logic [RASTER_CSR_ADDR_BITS-1:0]  csr_addr_t;

  typedef struct packed {
    csr_data_t  pidx_addr;
    csr_data_t  pidx_size;
    csr_data_t  pbuf_addr;
    csr_data_t  pbuf_stride;
    tile_data_t tile_left;
    tile_data_t tile_top;
    tile_data_t tile_width;
    tile_data_t tile_height;
  } raster_csrs_t;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StStart
  } raster_csr_state_t;

  // Wrapping subtract; callers treat any offset >= RASTER_CSR_COUNT as out of range.
  function automatic csr_addr_t csr_offset(input csr_addr_t addr, input csr_addr_t base);
    return addr - base;
  endfunction

  function automatic csr_data_t tile_zext(input tile_data_t val);
    return {{(RASTER_CSR_DATA_BITS - RASTER_TILE_DATA_BITS){1'b0}}, val};
  endfunction

  function automatic csr_data_t csr_field_read(input raster_csrs_t csrs, input logic [3:0] idx);
    csr_data_t res;
    res = '0;
    case (idx)
      RASTER_CSR_PIDX_ADDR:   res = csrs.pidx_addr;
      RASTER_CSR_PIDX_SIZE:   res = csrs.pidx_size;
      RASTER_CSR_PBUF_ADDR:   res = csrs.pbuf_addr;
      RASTER_CSR_PBUF_STRIDE: res = csrs.pbuf_stride;
      RASTER_CSR_TILE_LEFT:   res = tile_zext(csrs.tile_left);
      RASTER_CSR_TILE_TOP:    res = tile_zext(csrs.tile_top);
      RASTER_CSR_TILE_WIDTH:  res = tile_zext(csrs.tile_width);
      RASTER_CSR_TILE_HEIGHT: res = tile_zext(csrs.tile_height);
      default:                res = '0;
    endcase
    return res;
  endfunction

  function automatic raster_csrs_t csr_field_write(input raster_csrs_t csrs,
                                                   input logic [3:0] idx,
                                                   input csr_data_t data);
    raster_csrs_t res;
    res = csrs;
    case (idx)
      RASTER_CSR_PIDX_ADDR:   res.pidx_addr   = data;
      RASTER_CSR_PIDX_SIZE:   res.pidx_size   = data;
      RASTER_CSR_PBUF_ADDR:   res.pbuf_addr   = data;
      RASTER_CSR_PBUF_STRIDE: res.pbuf_stride = data;
      RASTER_CSR_TILE_LEFT:   res.tile_left   = data[RASTER_TILE_DATA_BITS-1:0];
      RASTER_CSR_TILE_TOP:    res.tile_top    = data[RASTER_TILE_DATA_BITS-1:0];
      RASTER_CSR_TILE_WIDTH:  res.tile_width  = data[RASTER_TILE_DATA_BITS-1:0];
      RASTER_CSR_TILE_HEIGHT: res.tile_height = data[RASTER_TILE_DATA_BITS-1:0];
      default:                res = csrs;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vx_raster_csr_if.sv
// CSR request/response channels plus the raster-side configuration and start handshake.
interface vx_raster_csr_if import vx_raster_csr_pkg::*; ();

  logic         csr_wr_valid;
  logic         csr_wr_ready;
  csr_addr_t    csr_wr_addr;
  csr_data_t    csr_wr_data;

  logic         csr_rd_valid;
  logic         csr_rd_ready;
  csr_addr_t    csr_rd_addr;

  logic         csr_rsp_valid;
  logic         csr_rsp_ready;
  csr_data_t    csr_rsp_data;
  logic         csr_rsp_err;

  logic         raster_busy;
  raster_csrs_t raster_csrs;
  logic         raster_start_valid;
  logic         raster_start_ready;

  // Requester / raster-pipeline side.
  modport master (
    output csr_wr_valid, csr_wr_addr, csr_wr_data,
    input  csr_wr_ready,
    output csr_rd_valid, csr_rd_addr,
    input  csr_rd_ready,
    input  csr_rsp_valid, csr_rsp_data, csr_rsp_err,
    output csr_rsp_ready,
    output raster_busy, raster_start_ready,
    input  raster_csrs, raster_start_valid
  );

  // Responder side.
  modport slave (
    input  csr_wr_valid, csr_wr_addr, csr_wr_data,
    output csr_wr_ready,
    input  csr_rd_valid, csr_rd_addr,
    output csr_rd_ready,
    output csr_rsp_valid, csr_rsp_data, csr_rsp_err,
    input  csr_rsp_ready,
    input  raster_busy, raster_start_ready,
    output raster_csrs, raster_start_valid
  );

endinterface

// File: rtl/vx_raster_csr.sv
// Raster CSR responder: shadow configuration written over the CSR path, committed atomically
// into the active bundle only while the raster pipeline is idle.
module vx_raster_csr import vx_raster_csr_pkg::*; #(
  parameter logic [11:0] CSR_BASE = 12'h7C0
) (
  input logic            clk,
  input logic            reset,
  vx_raster_csr_if.slave csr_if
);

  raster_csr_state_t state_q, state_d;
  raster_csrs_t      shadow_q, shadow_d;
  raster_csrs_t      active_q, active_d;

  logic      rsp_valid_q, rsp_valid_d;
  csr_data_t rsp_data_q, rsp_data_d;
  logic      rsp_err_q, rsp_err_d;

  csr_addr_t  wr_off, rd_off;
  logic [3:0] wr_idx, rd_idx;
  logic       wr_in_range, rd_in_range;
  logic       wr_is_ctrl, wr_ready, wr_fire, commit;
  logic       rd_ready, rd_fire;
  logic       start_valid;

  // Address decode and handshakes.
  always_comb begin
    wr_off      = csr_offset(csr_if.csr_wr_addr, CSR_BASE);
    rd_off      = csr_offset(csr_if.csr_rd_addr, CSR_BASE);
    wr_in_range = (wr_off < csr_addr_t'(RASTER_CSR_COUNT));
    rd_in_range = (rd_off < csr_addr_t'(RASTER_CSR_COUNT));
    wr_idx      = wr_off[3:0];
    rd_idx      = rd_off[3:0];
    wr_is_ctrl  = wr_in_range && (wr_idx == RASTER_CSR_CTRL);
    // Only CTRL writes can stall, so field updates keep flowing during a commit.
    wr_ready    = !(wr_is_ctrl && (state_q != StIdle));
    wr_fire     = csr_if.csr_wr_valid && wr_ready;
    commit      = wr_fire && wr_is_ctrl && csr_if.csr_wr_data[0];
    rd_ready    = !rsp_valid_q || csr_if.csr_rsp_ready;
    rd_fire     = csr_if.csr_rd_valid && rd_ready;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (wr_fire && wr_in_range && !wr_is_ctrl) begin
      shadow_d = csr_field_write(shadow_q, wr_idx, csr_if.csr_wr_data);
    end
  end

  // Commit FSM; active copies shadow_q so a same-cycle write lands in shadow only.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    start_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          state_d = StPending;
        end
      end
      StPending: begin
        if (!csr_if.raster_busy) begin
          active_d = shadow_q;
          state_d  = StStart;
        end
      end
      StStart: begin
        start_valid = 1'b1;
        if (csr_if.raster_start_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // One-entry response register; a read sees shadow_q, i.e. the pre-write value.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      if (!rd_in_range) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end else if (rd_idx == RASTER_CSR_CTRL) begin
        rsp_data_d = {{(RASTER_CSR_DATA_BITS - 2){1'b0}},
                      (state_q == StStart), (state_q == StPending)};
        rsp_err_d  = 1'b0;
      end else begin
        rsp_data_d = csr_field_read(shadow_q, rd_idx);
        rsp_err_d  = 1'b0;
      end
    end else if (csr_if.csr_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      active_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign csr_if.csr_wr_ready       = wr_ready;
  assign csr_if.csr_rd_ready       = rd_ready;
  assign csr_if.csr_rsp_valid      = rsp_valid_q;
  assign csr_if.csr_rsp_data       = rsp_data_q;
  assign csr_if.csr_rsp_err        = rsp_err_q;
  assign csr_if.raster_csrs        = active_q;
  assign csr_if.raster_start_valid = start_valid;

endmodule

// File: tb/tb_vx_raster_csr.sv
// Self-checking bench for vx_raster_csr against an array-based model of the CSR rules.
module tb_vx_raster_csr;
  import vx_raster_csr_pkg::*;

  localparam logic [11:0] Base = 12'h7C0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_raster_csr_if bus ();

  vx_raster_csr #(.CSR_BASE(Base)) dut (
    .clk    (clk),
    .reset  (reset),
    .csr_if (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_shadow [8];
  logic [31:0] m_active [8];
  bit          m_pending;
  bit          m_announce;
  bit          m_rsp_valid;
  logic [31:0] m_rsp_data;
  bit          m_rsp_err;
  int          rd_accepted;
  int          rsp_delivered;
  logic [191:0] held_csrs;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] model_csrs();
    logic [15:0] t4, t5, t6, t7;
    t4 = m_active[4][15:0];
    t5 = m_active[5][15:0];
    t6 = m_active[6][15:0];
    t7 = m_active[7][15:0];
    return {m_active[0], m_active[1], m_active[2], m_active[3], t4, t5, t6, t7};
  endfunction

  // Returns {err, data} for a read at addr given the current model.
  function automatic logic [32:0] model_read(input logic [11:0] addr);
    int off;
    off = int'(addr) - int'(Base);
    if (off < 0 || off > 8) return {1'b1, 32'h0};
    if (off == 8) return {1'b0, 30'b0, m_announce, m_pending};
    return {1'b0, m_shadow[off]};
  endfunction

  task automatic clr();
    bus.csr_wr_valid = 1'b0;
    bus.csr_rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_wr_valid = 1'b1;
    bus.csr_wr_addr  = a;
    bus.csr_wr_data  = d;
  endtask

  task automatic rd(input logic [11:0] a);
    bus.csr_rd_valid = 1'b1;
    bus.csr_rd_addr  = a;
  endtask

  // One clock with the currently driven inputs; model advances and all outputs are checked.
  task automatic step();
    int woff;
    bit exp_wr_ready, exp_rd_ready, wr_fire, rd_fire;
    logic [32:0] r;
    #1;
    woff = int'(bus.csr_wr_addr) - int'(Base);
    exp_wr_ready = !(woff == 8 && (m_pending || m_announce));
    exp_rd_ready = !m_rsp_valid || bus.csr_rsp_ready;
    check("wr_ready", bus.csr_wr_ready, exp_wr_ready);
    check("rd_ready", bus.csr_rd_ready, exp_rd_ready);
    wr_fire = bus.csr_wr_valid && exp_wr_ready;
    rd_fire = bus.csr_rd_valid && exp_rd_ready;
    if (m_rsp_valid && bus.csr_rsp_ready) rsp_delivered++;
    if (rd_fire) begin
      r = model_read(bus.csr_rd_addr);
      m_rsp_valid = 1'b1;
      m_rsp_err   = r[32];
      m_rsp_data  = r[31:0];
      rd_accepted++;
    end else if (bus.csr_rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
    if (m_announce && bus.raster_start_ready) begin
      m_announce = 1'b0;
    end else if (m_pending && !bus.raster_busy) begin
      m_active   = m_shadow;
      m_pending  = 1'b0;
      m_announce = 1'b1;
    end else if (wr_fire && woff == 8 && bus.csr_wr_data[0]) begin
      m_pending = 1'b1;
    end
    if (wr_fire && woff >= 0 && woff < 8) begin
      m_shadow[woff] = (woff >= 4) ? (bus.csr_wr_data & 32'h0000_FFFF) : bus.csr_wr_data;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", bus.csr_rsp_valid, m_rsp_valid);
    if (m_rsp_valid) begin
      check("rsp_data", bus.csr_rsp_data, m_rsp_data);
      check("rsp_err", bus.csr_rsp_err, m_rsp_err);
    end
    check("start_valid", bus.raster_start_valid, m_announce);
    check("raster_csrs", bus.raster_csrs, model_csrs());
  endtask

  task automatic do_reset();
    clr();
    bus.csr_rsp_ready      = 1'b1;
    bus.raster_busy        = 1'b0;
    bus.raster_start_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending   = 1'b0;
    m_announce  = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    m_rsp_err   = 1'b0;
    rd_accepted   = 0;
    rsp_delivered = 0;
    check("rst_rsp_valid", bus.csr_rsp_valid, 1'b0);
    check("rst_rsp_data", bus.csr_rsp_data, 32'h0);
    check("rst_rsp_err", bus.csr_rsp_err, 1'b0);
    check("rst_start_valid", bus.raster_start_valid, 1'b0);
    check("rst_csrs", bus.raster_csrs, 192'h0);
    check("rst_wr_ready", bus.csr_wr_ready, 1'b1);
    check("rst_rd_ready", bus.csr_rd_ready, 1'b1);
  endtask

  initial begin
    bus.csr_wr_addr = '0;
    bus.csr_wr_data = '0;
    bus.csr_rd_addr = '0;
    do_reset();

    // Reset-state reads: in range and just past the decoded window.
    rd(Base); step();
    check("rd_idx0_data", bus.csr_rsp_data, 32'h0);
    check("rd_idx0_err", bus.csr_rsp_err, 1'b0);
    rd(Base + 12'd9); step();
    check("rd_oor_data", bus.csr_rsp_data, 32'h0);
    check("rd_oor_err", bus.csr_rsp_err, 1'b1);
    clr(); step();

    // Tile truncation and full-width field.
    wr(Base + 12'd4, 32'h1234_5678); step(); clr();
    rd(Base + 12'd4); step();
    check("tile_left_trunc", bus.csr_rsp_data, 32'h0000_5678);
    clr();
    wr(Base + 12'd2, 32'hDEAD_BEEF); step(); clr();
    rd(Base + 12'd2); step();
    check("pbuf_addr_full", bus.csr_rsp_data, 32'hDEAD_BEEF);
    clr(); step();

    // Program everything, commit while idle, hold the start handshake.
    for (int i = 0; i < 8; i++) begin
      wr(Base + 12'(i), $urandom); step();
    end
    clr();
    bus.raster_start_ready = 1'b0;
    wr(Base + 12'd8, 32'h1); step(); clr();
    check("start_not_yet", bus.raster_start_valid, 1'b0);
    step();
    check("start_rise", bus.raster_start_valid, 1'b1);
    held_csrs = bus.raster_csrs;
    for (int i = 0; i < 5; i++) begin
      step();
      check("start_hold_valid", bus.raster_start_valid, 1'b1);
      check("start_hold_csrs", bus.raster_csrs, held_csrs);
    end
    bus.raster_start_ready = 1'b1; step();
    check("start_done", bus.raster_start_valid, 1'b0);

    // Commit while busy: CTRL reads 1, CTRL writes stall, field writes still land.
    bus.raster_busy = 1'b1;
    wr(Base + 12'd8, 32'h1); step(); clr();
    for (int k = 0; k < 10; k++) begin
      bus.csr_wr_valid = 1'b0;
      rd(Base + 12'd8);
      if (k == 2 || k == 3) wr(Base + 12'd8, 32'h1);
      if (k == 5) wr(Base + 12'd1, 32'd7);
      step();
      check("busy_ctrl_read", bus.csr_rsp_data, 32'h1);
    end
    clr();
    bus.raster_busy = 1'b0;
    step();
    check("busy_pidx_size", bus.raster_csrs.pidx_size, 32'd7);
    step();

    // Back-pressured back-to-back reads.
    for (int i = 0; i < 40; i++) begin
      rd(Base + 12'($urandom_range(0, 10)));
      bus.csr_rsp_ready = (i < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end
    clr();
    bus.csr_rsp_ready = 1'b1;
    step(); step();
    check("rsp_count", 192'(rsp_delivered), 192'(rd_accepted));

    // Randomised mix of everything.
    for (int i = 0; i < 300; i++) begin
      bus.csr_wr_valid       = 1'($urandom_range(0, 1));
      bus.csr_wr_addr        = Base + 12'($urandom_range(0, 10));
      bus.csr_wr_data        = $urandom;
      bus.csr_rd_valid       = 1'($urandom_range(0, 1));
      bus.csr_rd_addr        = Base + 12'($urandom_range(0, 10));
      bus.csr_rsp_ready      = ($urandom_range(0, 3) != 0);
      bus.raster_busy        = ($urandom_range(0, 2) == 0);
      bus.raster_start_ready = 1'($urandom_range(0, 1));
      step();
    end
    clr();
    bus.csr_rsp_ready      = 1'b1;
    bus.raster_busy        = 1'b0;
    bus.raster_start_ready = 1'b1;
    step(); step(); step();
    check("rand_rsp_count", 192'(rsp_delivered), 192'(rd_accepted));

    // Reset while announcing a new configuration.
    bus.raster_start_ready = 1'b0;
    wr(Base + 12'd0, 32'hCAFE_0001); step(); clr();
    wr(Base + 12'd8, 32'h1); step(); clr();
    step();
    check("pre_rst_start", bus.raster_start_valid, 1'b1);
    do_reset();
    rd(Base + 12'd8); step();
    check("post_rst_ctrl", bus.csr_rsp_data, 32'h0);
    clr(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_raster_csr.md
# VX_raster_csr

Raster-unit CSR responder: accepts CSR writes and reads from the core-side CSR path, holds a shadow copy of the raster configuration, and on a commit request atomically transfers it into the active `raster_csrs_t` bundle consumed by the raster pipeline. It is the producer end of the `raster_csrs_t` interface and sits between the CSR unit and the raster front-end. Its handshakes guarantee that the active configuration never changes while the raster unit is busy.

## Interface
Parameters:
- `CSR_BASE`, default 12'h7C0: CSR address of index 0; indices 0..8 are decoded, and every other address is out of range.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `csr_wr_valid` / `csr_wr_ready`  in/out  1/1  write request handshake.
- `csr_wr_addr`  in  12  write CSR address.
- `csr_wr_data`  in  `RASTER_CSR_DATA_BITS` (32)  write data.
- `csr_rd_valid` / `csr_rd_ready`  in/out  1/1  read request handshake.
- `csr_rd_addr`  in  12  read CSR address.
- `csr_rsp_valid` / `csr_rsp_ready`  out/in  1/1  read response handshake.
- `csr_rsp_data`  out  32  read data.
- `csr_rsp_err`  out  1  read address out of range.
- `raster_busy`  in  1  raster pipeline is consuming the active configuration.
- `raster_csrs`  out  `raster_csrs_t`  active configuration.
- `raster_start_valid` / `raster_start_ready`  out/in  1/1  new-configuration start handshake.

## Operation
- Index map:
  - 0 `pidx_addr`, 1 `pidx_size`, 2 `pbuf_addr`, 3 `pbuf_stride`.
  - 4 `tile_left`, 5 `tile_top`, 6 `tile_width`, 7 `tile_height`.
  - 8 CTRL.
- Writes:
  - Indices 0..7 update the shadow register.
  - Tile fields keep the low `RASTER_TILE_DATA_BITS` (16) bits of the write data and drop the upper bits.
  - Out-of-range writes are accepted and dropped.
- Write readiness:
  - `csr_wr_ready` is 1, except that a write to CTRL stalls (`csr_wr_ready`=0 for that request) while the state is not IDLE.
- CTRL write:
  - Data bit0=1 is a commit request.
  - Bit0=0 is accepted as a no-op.
- Reads:
  - Indices 0..7 return the shadow value; tile fields are zero-extended.
  - CTRL returns {30'b0, state==START, state==PENDING}.
  - Out-of-range reads return data 0 with `csr_rsp_err`=1.
- State machine:
  - IDLE: a commit is accepted → PENDING.
  - PENDING: stays while `raster_busy`=1. When `raster_busy`=0, active ← shadow (all 8 fields in the same cycle) and the state → START.
  - START: `raster_start_valid`=1, held until `raster_start_ready`=1, then → IDLE.
- Shadow writes remain legal in PENDING and START.
  - A shadow write in the cycle that copies shadow to active is not included in the copy. The copy takes the pre-write shadow value.
  - That write lands in the shadow only.
- Simultaneous read and write to the same index: the response carries the pre-write value.
- Reset:
  - Shadow, active, and `raster_csrs` are all 0.
  - State is IDLE.
  - `csr_rsp_valid`=0, `csr_rsp_data`=0, `csr_rsp_err`=0.
  - `raster_start_valid`=0.
  - `csr_wr_ready`=1 and `csr_rd_ready`=1 from the first cycle after reset.
- Reset mid-operation drops any pending commit, any un-accepted start, and any held response.

## Timing
- Write: takes effect at the edge where `csr_wr_valid && csr_wr_ready`. The shadow value is readable by a read accepted in the following cycle.
- Read:
  - One-cycle latency: a request accepted at edge t gives a registered response valid after edge t.
  - The response is held stable until `csr_rsp_ready`.
  - `csr_rd_ready` = !`csr_rsp_valid` || `csr_rsp_ready`, which gives full throughput of one read per cycle.
- Commit latency (commit accepted at edge t, `raster_busy`=0):
  - PENDING after t.
  - After edge t+1: `raster_csrs` is updated and `raster_start_valid`=1.
  - `raster_csrs` changes only on the PENDING→START edge.
- Start handshake: while `raster_start_valid` is asserted it never deasserts, and `raster_csrs` stays constant, until the handshake completes.

## Structure
- Add to package `raster_types`:
  - Localparams `RASTER_CSR_PIDX_ADDR`…`RASTER_CSR_TILE_HEIGHT`, `RASTER_CSR_CTRL` (index 8) and `RASTER_CSR_COUNT`=9.
  - Enum `raster_csr_state_t` {IDLE, PENDING, START}.
  - The existing `raster_csrs_t` is reused for both the shadow and active registers.
- Sub-modules: none required. Build the read response stage as a one-entry output register with a valid/ready skid rule; it stays inline.

## Test plan
- Reset: all outputs at their reset values. Reading index 0 returns 0 with err=0; reading `CSR_BASE+9` returns 0 with err=1.
- Write 32'h1234_5678 to `tile_left` → read returns 32'h0000_5678. Write 32'hDEAD_BEEF to `pbuf_addr` → read returns it unchanged.
- Program all 8 fields, commit with `raster_busy`=0 → `raster_csrs` matches the shadow and `raster_start_valid` rises 2 cycles after the commit. Hold `raster_start_ready`=0 for 5 cycles → valid and `raster_csrs` stay stable.
- Commit with `raster_busy`=1 for 10 cycles:
  - CTRL reads 1 throughout.
  - A second CTRL write stalls.
  - `pidx_size` written to 7 during the wait appears in `raster_csrs` after the busy signal drops.
- Hold `csr_rsp_ready`=0 with back-to-back reads → `csr_rd_ready` drops, the response is held, and no response is lost or duplicated.
- Assert reset in the START state → start valid drops, state is IDLE, and `raster_csrs`=0.
